// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide unit for the multicycle CPU.
// Owns HI/LO, runs one shift-add or restoring-divide step per clock, and flags divide-by-zero.
//
// Handshake: start is sampled only while the FSM is IDLE (busy=0).
// An accepted request raises busy on the next cycle and keeps it high for WIDTH+1 cycles.
// done then pulses for one cycle, and HI/LO are valid from that cycle on.
// A rejected DIV (divisor 0) leaves busy low and pulses div_by_zero instead.
// start while busy is dropped and does not queue.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_accept;
  logic             w_reject;

  logic             r_op;
  logic             r_neg_main;
  logic             r_neg_rem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo_s;
  logic [WIDTH-1:0]   w_rem_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next state and request decode
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (op && (operand_b == '0)) begin
            w_reject = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_next_state = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_ITER) w_next_state = S_FINISH;
      end
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Datapath: magnitudes, one iteration step, and final sign correction
  always_comb begin
    w_a_mag  = operand_a[WIDTH-1] ? (-operand_a) : operand_a;
    w_b_mag  = operand_b[WIDTH-1] ? (-operand_b) : operand_b;
    // MULT: r_opnd is |a|, r_acc_lo starts as |b| and is consumed LSB first
    w_sum    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
    // DIV: r_opnd is |b|, r_acc_lo starts as |a| and fills with quotient bits
    w_shift  = {r_acc_hi, r_acc_lo[WIDTH-1]};
    w_ge     = (w_shift >= {1'b0, r_opnd});
    w_diff   = w_shift[WIDTH-1:0] - r_opnd;
    w_prod   = {r_acc_hi, r_acc_lo};
    w_prod_s = r_neg_main ? (-w_prod) : w_prod;
    w_quo_s  = r_neg_main ? (-r_acc_lo) : r_acc_lo;
    w_rem_s  = r_neg_rem ? (-r_acc_hi) : r_acc_hi;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op       <= 1'b0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_cnt      <= '0;
      r_opnd     <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      r_done <= (r_state == S_FINISH);
      r_dbz  <= w_reject;
      if (w_accept) begin
        r_op       <= op;
        r_neg_main <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
        r_neg_rem  <= operand_a[WIDTH-1];
        r_cnt      <= '0;
        r_acc_hi   <= '0;
        r_opnd     <= op ? w_b_mag : w_a_mag;
        r_acc_lo   <= op ? w_a_mag : w_b_mag;
      end else if (r_state == S_RUN) begin
        r_cnt <= (r_cnt == LAST_ITER) ? '0 : (r_cnt + CW'(1));
        if (r_op) begin
          r_acc_hi <= w_ge ? w_diff : w_shift[WIDTH-1:0];
          r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
        end else begin
          r_acc_hi <= w_sum[WIDTH:1];
          r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
        end
      end
      if (r_state == S_FINISH) begin
        if (r_op) begin
          r_hi <= w_rem_s;
          r_lo <= w_quo_s;
        end else begin
          r_hi <= w_prod_s[2*WIDTH-1:WIDTH];
          r_lo <= w_prod_s[WIDTH-1:0];
        end
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign dbg_state   = r_state;

endmodule
